sisr_sig_check: RTL and testbench

SISR_SIG_CHECK -- requirements
Module: sisr_sig_check

---
 rtl/sisr_pkg.sv | 25 ++
 rtl/sisr4_en.sv | 56 +++++
 rtl/sisr_sig_check.sv | 169 ++++++++++++++++
 tb/tb_sisr_sig_check.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisr_pkg.sv
// sisr_pkg
// Shared definitions for the serial-signature checker:
//   - state_t     : checker FSM states (IDLE, RUN, CHECK)
//   - SIG_W       : signature register width
//   - FB_TAPS     : feedback tap mask for x^4+x+1 (feedback into bits 0 and 1)
//   - TIMEOUT_W   : idle counter width (used only when SIG_CHECK_TIMEOUT_EN is defined)
//   - TIMEOUT_MAX : consecutive idle RUN cycles that abort a run
package sisr_pkg;

   localparam int SIG_W = 4;

   // Bit i of the next signature is shift_in[i] ^ (FB_TAPS[i] & msb).
   // The x^4 term is implicit in the shift, and the x and 1 terms are bits 1 and 0.
   localparam logic [SIG_W-1:0] FB_TAPS = 4'b0011;

   localparam int TIMEOUT_W = 8;
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 8'd255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2
   } state_t;

endpackage

// File: rtl/sisr4_en.sv
// sisr4_en
// A 4-bit single-input signature register with enable and synchronous clear.
// The register compacts one serial bit per enabled cycle, using the polynomial x^4+x+1.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (clears the signature)
//   clr    in   synchronous clear; takes priority over en
//   en     in   compacts bit_in this cycle
//   bit_in in   serial data bit
//   sig    out  current signature
module sisr4_en
   import sisr_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;
   logic [SIG_W-1:0] shift_in;
   logic [SIG_W-1:0] next_sig;

   // Shift left and insert the new bit at the LSB. Then fold the MSB that is
   // shifted out back into the tap positions.
   assign shift_in = {sig_q[SIG_W-2:0], bit_in};

   generate
      for (genvar gi = 0; gi < SIG_W; gi++) begin : g_tap
         assign next_sig[gi] = shift_in[gi] ^ (FB_TAPS[gi] & sig_q[SIG_W-1]);
      end
   endgenerate

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = next_sig;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/sisr_sig_check.sv
// sisr_sig_check
// This module compacts a serial response stream of `len` bits into a 4-bit signature.
// It then compares the signature with a golden value.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   start    in   one-cycle run request. The module accepts it only in IDLE.
//   len      in   number of bits to compact. The module latches it when it accepts start.
//   golden   in   expected signature. The module latches it when it accepts start.
//   bit_in   in   serial response bit
//   bit_vld  in   qualifies bit_in. The module uses it only in RUN.
//   busy     out  high when the FSM is not in IDLE
//   done     out  one-cycle pulse at the end of a run
//   pass     out  compare result. It holds until the next accepted start.
//   sig      out  current signature
//   timeout  out  abort flag. It holds until the next accepted start.
// Build option: define SIG_CHECK_TIMEOUT_EN to abort a RUN after TIMEOUT_MAX
// consecutive cycles without bit_vld. Without this option, timeout is tied to 0.
module sisr_sig_check
   import sisr_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [SIG_W-1:0] golden,
   input  logic             bit_in,
   input  logic             bit_vld,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] sig,
   output logic             timeout
);

   localparam logic [LEN_W-1:0] LEN_ONE = 1;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [SIG_W-1:0] golden_q, golden_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             timeout_q, timeout_d;
   logic             start_acc;
   logic             bit_acc;

`ifdef SIG_CHECK_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] idle_q, idle_d;
`endif

   sisr4_en u_sisr (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_acc),
      .en     (bit_acc),
      .bit_in (bit_in),
      .sig    (sig)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      count_d   = count_q;
      golden_d  = golden_q;
      done_d    = 1'b0;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      start_acc = 1'b0;
      bit_acc   = 1'b0;
`ifdef SIG_CHECK_TIMEOUT_EN
      idle_d    = idle_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               len_d     = len;
               golden_d  = golden;
               count_d   = '0;
`ifdef SIG_CHECK_TIMEOUT_EN
               idle_d    = '0;
`endif
               // A zero-length run has nothing to compact. The signature
               // stays 0, so the module goes directly to the compare step.
               state_d   = (len == '0) ? CHECK : RUN;
            end
         end
         RUN: begin
            if (bit_vld) begin
               bit_acc = 1'b1;
               count_d = count_q + LEN_ONE;
`ifdef SIG_CHECK_TIMEOUT_EN
               idle_d  = '0;
`endif
               // The compare uses count_q before the increment. This way count
               // never has to hold len, and a run of 2^LEN_W-1 bits does not wrap it.
               if (count_q == len_q - LEN_ONE) begin
                  state_d = CHECK;
               end
            end
`ifdef SIG_CHECK_TIMEOUT_EN
            else if (idle_q == TIMEOUT_MAX - 8'd1) begin
               // This cycle is the TIMEOUT_MAX-th consecutive idle cycle.
               state_d   = IDLE;
               done_d    = 1'b1;
               pass_d    = 1'b0;
               timeout_d = 1'b1;
            end else begin
               idle_d = idle_q + 8'd1;
            end
`endif
         end
         CHECK: begin
            done_d  = 1'b1;
            pass_d  = (sig == golden_q);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         count_q   <= '0;
         golden_q  <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
`ifdef SIG_CHECK_TIMEOUT_EN
         idle_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         count_q   <= count_d;
         golden_q  <= golden_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
`ifdef SIG_CHECK_TIMEOUT_EN
         idle_q    <= idle_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign pass = pass_q;

`ifdef SIG_CHECK_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   // The run never aborts, so the flag is constant. The register stays
   // so that the start and reset behaviour match the timeout build.
   assign timeout = 1'b0;
   logic unused_timeout;
   assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_sisr_sig_check.sv
// tb_sisr_sig_check
// Self-checking bench for sisr_sig_check.
// The reference signature is the remainder of the bit stream, read as a
// polynomial, after division by x^4+x+1 (0x13).
module tb_sisr_sig_check;

   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic [3:0]       golden = '0;
   logic             bit_in = 1'b0;
   logic             bit_vld = 1'b0;
   logic             busy, done, pass, timeout;
   logic [3:0]       sig;

   int checks = 0;
   int failures = 0;

   logic       exp_pass_last = 1'b0;
   logic [3:0] last_sig = 4'h0;

   always #5 clk = ~clk;

   sisr_sig_check #(.LEN_W(LEN_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .len     (len),
      .golden  (golden),
      .bit_in  (bit_in),
      .bit_vld (bit_vld),
      .busy    (busy),
      .done    (done),
      .pass    (pass),
      .sig     (sig),
      .timeout (timeout)
   );

   // Append one bit to the stream polynomial and reduce it modulo x^4+x+1.
   function automatic logic [3:0] model_step(input logic [3:0] s, input logic b);
      int v;
      v = (int'(s) << 1) | int'(b);
      if (v >= 16) v = v ^ 'h13;
      return 4'(v);
   endfunction

   function automatic logic [3:0] model_sig(input int n, input logic [255:0] bits);
      logic [3:0] s;
      s = 4'h0;
      for (int i = 0; i < n; i++) s = model_step(s, bits[i]);
      return s;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // This task issues start, feeds n bits with `gap` idle cycles between them,
   // and stops in the cycle where done must be high.
   task automatic do_run(input int n, input logic [3:0] g, input logic [255:0] bits,
                         input int gap, input bit restart, input string tag);
      logic [3:0] exp_sig;
      exp_sig = 4'h0;
      start = 1'b1; len = n[LEN_W-1:0]; golden = g;
      tick;
      start = 1'b0; len = $urandom; golden = $urandom;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || pass !== 1'b0 || timeout !== 1'b0 || sig !== 4'h0) begin
         failures++;
         $display("FAIL %s start: done=%b busy=%b pass=%b timeout=%b sig=%h required done=0 busy=1 pass=0 timeout=0 sig=0",
                  tag, done, busy, pass, timeout, sig);
      end
      for (int i = 0; i < n; i++) begin
         bit_vld = 1'b1; bit_in = bits[i];
         tick;
         bit_vld = 1'b0; bit_in = $urandom;
         exp_sig = model_step(exp_sig, bits[i]);
         checks++;
         if (sig !== exp_sig || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s bit%0d: sig=%h busy=%b done=%b required sig=%h busy=1 done=0",
                     tag, i, sig, busy, done, exp_sig);
         end
         if (i < n - 1) begin
            for (int j = 0; j < gap; j++) begin
               if (restart && i == 0 && j == 0) begin
                  start = 1'b1; len = 8'd1; golden = ~g;
               end
               tick;
               start = 1'b0;
               checks++;
               if (sig !== exp_sig || busy !== 1'b1 || done !== 1'b0) begin
                  failures++;
                  $display("FAIL %s gap%0d.%0d: sig=%h busy=%b done=%b required sig=%h busy=1 done=0",
                           tag, i, j, sig, busy, done, exp_sig);
               end
            end
         end
      end
      tick;
      exp_pass_last = (exp_sig == g);
      last_sig = exp_sig;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || sig !== exp_sig || pass !== exp_pass_last || timeout !== 1'b0) begin
         failures++;
         $display("FAIL %s done: done=%b busy=%b sig=%h pass=%b timeout=%b required done=1 busy=0 sig=%h pass=%b timeout=0",
                  tag, done, busy, sig, pass, timeout, exp_sig, exp_pass_last);
      end
   endtask

   // The cycle after done: done must drop, and pass must hold.
   task automatic settle(input string tag);
      tick;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || pass !== exp_pass_last || sig !== last_sig) begin
         failures++;
         $display("FAIL %s settle: done=%b busy=%b pass=%b sig=%h required done=0 busy=0 pass=%b sig=%h",
                  tag, done, busy, pass, sig, exp_pass_last, last_sig);
      end
   endtask

   task automatic check_reset_state(input string tag);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0 || sig !== 4'h0) begin
         failures++;
         $display("FAIL %s: busy=%b done=%b pass=%b timeout=%b sig=%h required all 0",
                  tag, busy, done, pass, timeout, sig);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; len = 8'd3; bit_vld = 1'b1; bit_in = 1'b1;
      tick;
      tick;
      check_reset_state("reset");
      rst = 1'b0; start = 1'b0; bit_vld = 1'b0; bit_in = 1'b0;
      tick;
      check_reset_state("reset_idle");
      exp_pass_last = 1'b0; last_sig = 4'h0;
   endtask

   task automatic test_directed;
      do_run(4, 4'h8, 256'h1, 0, 1'b0, "golden8");
      checks++;
      if (sig !== 4'h8 || pass !== 1'b1) begin
         failures++;
         $display("FAIL golden8 const: sig=%h pass=%b required sig=8 pass=1", sig, pass);
      end
      settle("golden8");
      do_run(4, 4'h9, 256'h1, 0, 1'b0, "golden9");
      checks++;
      if (sig !== 4'h8 || pass !== 1'b0) begin
         failures++;
         $display("FAIL golden9 const: sig=%h pass=%b required sig=8 pass=0", sig, pass);
      end
      settle("golden9");
      do_run(5, 4'h3, 256'h1, 1, 1'b1, "len5_restart");
      checks++;
      if (sig !== 4'h3 || pass !== 1'b1) begin
         failures++;
         $display("FAIL len5_restart const: sig=%h pass=%b required sig=3 pass=1", sig, pass);
      end
      settle("len5_restart");
   endtask

   task automatic test_len0_and_midreset;
      do_run(0, 4'h0, 256'h0, 0, 1'b0, "len0");
      settle("len0");
      start = 1'b1; len = 8'd4; golden = 4'h8;
      tick;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bit_vld = 1'b1; bit_in = 1'b1;
         tick;
      end
      bit_vld = 1'b1; rst = 1'b1;
      tick;
      check_reset_state("midrun_reset");
      rst = 1'b0; bit_vld = 1'b0;
      tick;
      check_reset_state("midrun_reset_after");
      exp_pass_last = 1'b0; last_sig = 4'h0;
      do_run(4, 4'h8, 256'h1, 0, 1'b0, "after_reset");
      settle("after_reset");
   endtask

   task automatic test_back_to_back;
      logic [255:0] bits;
      bits = {$urandom, $urandom};
      do_run(3, model_sig(3, bits), bits, 0, 1'b0, "b2b_a");
      bits = {$urandom, $urandom};
      do_run(6, $urandom, bits, 0, 1'b0, "b2b_b");
      do_run(0, 4'h0, bits, 0, 1'b0, "b2b_len0");
      bits = {$urandom, $urandom};
      do_run(2, model_sig(2, bits), bits, 2, 1'b1, "b2b_c");
      settle("b2b");
   endtask

   task automatic test_idle_vld;
      for (int i = 0; i < 3; i++) begin
         bit_vld = 1'b1; bit_in = i[0] ^ 1'b1;
         tick;
         checks++;
         if (sig !== last_sig || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_vld%0d: sig=%h busy=%b done=%b required sig=%h busy=0 done=0",
                     i, sig, busy, done, last_sig);
         end
      end
      bit_vld = 1'b0;
   endtask

   task automatic test_random;
      logic [255:0] bits;
      logic [3:0]   g;
      int           n, gap;
      for (int k = 0; k < 8; k++) begin
         bits = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         n    = $urandom_range(1, 40);
         gap  = $urandom_range(0, 2);
         g    = ($urandom_range(0, 1) == 1) ? model_sig(n, bits) : 4'($urandom);
         do_run(n, g, bits, gap, (gap > 0), "random");
         settle("random");
      end
   endtask

   task automatic test_timeout;
      start = 1'b1; len = 8'd4; golden = 4'h8;
      tick;
      start = 1'b0;
`ifdef SIG_CHECK_TIMEOUT_EN
      for (int i = 0; i < 254; i++) tick;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early: busy=%b done=%b timeout=%b required busy=1 done=0 timeout=0",
                  busy, done, timeout);
      end
      tick;
      checks++;
      if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_abort: done=%b timeout=%b pass=%b busy=%b required done=1 timeout=1 pass=0 busy=0",
                  done, timeout, pass, busy);
      end
      tick;
      checks++;
      if (done !== 1'b0 || timeout !== 1'b1) begin
         failures++;
         $display("FAIL timeout_hold: done=%b timeout=%b required done=0 timeout=1", done, timeout);
      end
      exp_pass_last = 1'b0; last_sig = 4'h0;
`else
      for (int i = 0; i < 300; i++) tick;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL no_timeout_wait: busy=%b done=%b timeout=%b required busy=1 done=0 timeout=0",
                  busy, done, timeout);
      end
      for (int i = 0; i < 4; i++) begin
         bit_vld = 1'b1; bit_in = (i == 0);
         tick;
      end
      bit_vld = 1'b0;
      tick;
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || sig !== 4'h8 || timeout !== 1'b0) begin
         failures++;
         $display("FAIL no_timeout_end: done=%b pass=%b sig=%h timeout=%b required done=1 pass=1 sig=8 timeout=0",
                  done, pass, sig, timeout);
      end
      exp_pass_last = 1'b1; last_sig = 4'h8;
`endif
      settle("timeout");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_len0_and_midreset();
      test_back_to_back();
      test_idle_vld();
      test_random();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
